// File: rtl/params.sv
// Project-wide sizing constants shared by the modulation blocks.
package params;
   localparam int unsigned NumSegment = 2;
endpackage

// File: rtl/modulation_timer_if.sv
// Settings/time inputs and per-segment index outputs of the modulation timer.
interface modulation_timer_if #(
   parameter int unsigned NUM_SEGMENT = params::NumSegment,
   parameter int unsigned DIV_WIDTH   = 16
);
   localparam int unsigned TimeW = 56;
   localparam int unsigned IdxW  = 15;

   logic [TimeW-1:0]     SYS_TIME;
   logic                 UPDATE_SETTINGS;
   logic [DIV_WIDTH-1:0] FREQ_DIV [NUM_SEGMENT];
   logic [IdxW-1:0]      CYCLE    [NUM_SEGMENT];
   logic [IdxW-1:0]      SYNC_IDX [NUM_SEGMENT];
   logic                 IDX_VALID;

   modport master (
      output SYS_TIME, UPDATE_SETTINGS, FREQ_DIV, CYCLE,
      input  SYNC_IDX, IDX_VALID
   );

   modport slave (
      input  SYS_TIME, UPDATE_SETTINGS, FREQ_DIV, CYCLE,
      output SYNC_IDX, IDX_VALID
   );
endinterface

// File: rtl/modulation_timer.sv
// Per-segment modulation index SYNC_IDX[s] = (SYS_TIME / FREQ_DIV[s]) mod (CYCLE[s]+1),
// computed by one shared bit-serial divider that visits the segments round-robin.
module modulation_timer #(
   parameter int unsigned NUM_SEGMENT = params::NumSegment,
   parameter int unsigned DIV_WIDTH   = 16
) (
   input logic               CLK,
   input logic               RST_N,
   modulation_timer_if.slave bus
);
   localparam int unsigned TimeW = 56;
   localparam int unsigned IdxW  = 15;
   localparam int unsigned LenW  = 16;
   localparam int unsigned CntW  = 6;
   localparam int unsigned SegW  = (NUM_SEGMENT > 1) ? $clog2(NUM_SEGMENT) : 1;
   localparam logic [CntW-1:0] LastIter = CntW'(TimeW - 1);

   typedef enum logic [1:0] {LATCH, DIV, MOD, WRITE} state_t;

   state_t               state, state_nxt;
   logic [SegW-1:0]      seg, seg_nxt;
   logic [CntW-1:0]      cnt, cnt_nxt;
   logic [TimeW-1:0]     dvd, dvd_nxt;
   logic [DIV_WIDTH-1:0] dsr, dsr_nxt;
   logic [DIV_WIDTH-1:0] drem, drem_nxt;
   logic [LenW-1:0]      len, len_nxt;
   logic [LenW-1:0]      mrem, mrem_nxt;
   logic                 div_zero, div_zero_nxt;
   logic [DIV_WIDTH:0]   div_trial;
   logic [LenW:0]        mod_trial;
   logic                 wr_c;
   logic                 idx_valid;
   logic [IdxW-1:0]      sync_idx [NUM_SEGMENT];

   // dvd holds the dividend, is refilled with quotient bits during DIV, then feeds MOD
   always_comb begin
      state_nxt    = state;
      seg_nxt      = seg;
      cnt_nxt      = cnt;
      dvd_nxt      = dvd;
      dsr_nxt      = dsr;
      drem_nxt     = drem;
      len_nxt      = len;
      mrem_nxt     = mrem;
      div_zero_nxt = div_zero;
      wr_c         = 1'b0;
      div_trial    = {drem, dvd[TimeW-1]};
      mod_trial    = {mrem, dvd[TimeW-1]};

      unique case (state)
         LATCH: begin
            dvd_nxt      = bus.SYS_TIME;
            dsr_nxt      = bus.FREQ_DIV[seg];
            len_nxt      = LenW'({1'b0, bus.CYCLE[seg]}) + LenW'(1);
            div_zero_nxt = (bus.FREQ_DIV[seg] == '0);
            drem_nxt     = '0;
            mrem_nxt     = '0;
            cnt_nxt      = '0;
            state_nxt    = DIV;
         end
         DIV: begin
            if (div_trial >= {1'b0, dsr}) begin
               drem_nxt = DIV_WIDTH'(div_trial - {1'b0, dsr});
               dvd_nxt  = {dvd[TimeW-2:0], 1'b1};
            end else begin
               drem_nxt = DIV_WIDTH'(div_trial);
               dvd_nxt  = {dvd[TimeW-2:0], 1'b0};
            end
            cnt_nxt = cnt + CntW'(1);
            if (cnt == LastIter) begin
               cnt_nxt   = '0;
               state_nxt = MOD;
            end
         end
         MOD: begin
            if (mod_trial >= {1'b0, len}) begin
               mrem_nxt = LenW'(mod_trial - {1'b0, len});
            end else begin
               mrem_nxt = LenW'(mod_trial);
            end
            dvd_nxt = {dvd[TimeW-2:0], 1'b0};
            cnt_nxt = cnt + CntW'(1);
            if (cnt == LastIter) begin
               cnt_nxt   = '0;
               state_nxt = WRITE;
            end
         end
         WRITE: begin
            wr_c      = 1'b1;
            seg_nxt   = (seg == SegW'(NUM_SEGMENT - 1)) ? '0 : seg + SegW'(1);
            state_nxt = LATCH;
         end
      endcase

      // a settings change restarts the sweep and discards the result in flight
      if (bus.UPDATE_SETTINGS) begin
         wr_c      = 1'b0;
         seg_nxt   = '0;
         state_nxt = LATCH;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state     <= LATCH;
         seg       <= '0;
         cnt       <= '0;
         dvd       <= '0;
         dsr       <= '0;
         drem      <= '0;
         len       <= '0;
         mrem      <= '0;
         div_zero  <= 1'b0;
         idx_valid <= 1'b0;
         sync_idx  <= '{default: '0};
      end else begin
         state     <= state_nxt;
         seg       <= seg_nxt;
         cnt       <= cnt_nxt;
         dvd       <= dvd_nxt;
         dsr       <= dsr_nxt;
         drem      <= drem_nxt;
         len       <= len_nxt;
         mrem      <= mrem_nxt;
         div_zero  <= div_zero_nxt;
         idx_valid <= wr_c;
         if (wr_c) begin
            sync_idx[seg] <= div_zero ? '0 : mrem[IdxW-1:0];
         end
      end
   end

   assign bus.SYNC_IDX  = sync_idx;
   assign bus.IDX_VALID = idx_valid;
endmodule

// File: tb/tb_modulation_timer.sv
// Randomized scoreboard bench for modulation_timer against an arithmetic reference model.
module tb_modulation_timer;
   localparam int unsigned NSEG   = 2;
   localparam int unsigned DW     = 16;
   localparam int unsigned PERIOD = 114;

   typedef struct {
      int unsigned seg;
      logic [14:0] val;
      int unsigned mod_len;
   } exp_t;

   logic clk;
   logic rst_n;
   logic [55:0] sys_time;
   int   time_mode;   // 0 hold, 1 increment, 2 random
   int   total;
   int   bad;
   int   ph;
   bit   step_chk;
   exp_t exp_q [$];
   logic [14:0] exp_idx [NSEG];
   bit   have_last [NSEG];
   logic [14:0] last_val [NSEG];

   modulation_timer_if #(.NUM_SEGMENT(NSEG), .DIV_WIDTH(DW)) bus ();

   modulation_timer #(.NUM_SEGMENT(NSEG), .DIV_WIDTH(DW)) dut (
      .CLK   (clk),
      .RST_N (rst_n),
      .bus   (bus)
   );

   assign bus.SYS_TIME = sys_time;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input longint unsigned got, input longint unsigned want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h at t=%0t", nm, got, want, $time);
      end
   endtask

   function automatic logic [14:0] ref_idx(input longint unsigned t, input longint unsigned fd,
                                           input longint unsigned cy);
      if (fd == 0) return 15'd0;
      return 15'((t / fd) % (cy + 1));
   endfunction

   // SYS_TIME source
   always @(posedge clk) begin
      #1;
      if (time_mode == 1) sys_time = sys_time + 56'd1;
      else if (time_mode == 2) sys_time = {24'($urandom()), $urandom()};
   end

   // Reference model: after restart, segment k is sampled every PERIOD edges starting at edge 1
   always @(posedge clk) begin
      if (!rst_n || bus.UPDATE_SETTINGS) begin
         ph = 0;
         exp_q.delete();
         for (int s = 0; s < NSEG; s++) have_last[s] = 1'b0;
      end else begin
         ph++;
         if ((ph - 1) % PERIOD == 0) begin
            exp_t e;
            e.seg     = ((ph - 1) / PERIOD) % NSEG;
            e.mod_len = 32'(bus.CYCLE[e.seg]) + 1;
            e.val     = ref_idx(64'(bus.SYS_TIME), 64'(bus.FREQ_DIV[e.seg]),
                                64'(bus.CYCLE[e.seg]));
            exp_q.push_back(e);
         end
      end
   end

   // Monitor: IDX_VALID timing, result values and output stability
   always @(negedge clk) begin
      logic exp_v;
      exp_t e;
      exp_v = rst_n && (ph != 0) && (ph % PERIOD == 0);
      chk("idx_valid", 64'(bus.IDX_VALID), 64'(exp_v));
      if (exp_v && bus.IDX_VALID) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard: got IDX_VALID, want an expected entry (queue empty)");
         end else begin
            e = exp_q.pop_front();
            if (step_chk && have_last[e.seg]) begin
               chk("step", 64'((bus.SYNC_IDX[e.seg] == last_val[e.seg]) ||
                               (32'(bus.SYNC_IDX[e.seg]) == (32'(last_val[e.seg]) + 1) % e.mod_len)),
                   64'd1);
            end
            exp_idx[e.seg]   = e.val;
            have_last[e.seg] = 1'b1;
            last_val[e.seg]  = e.val;
         end
      end
      for (int s = 0; s < NSEG; s++) chk("sync_idx", 64'(bus.SYNC_IDX[s]), 64'(exp_idx[s]));
   end

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_update();
      bus.UPDATE_SETTINGS = 1'b1;
      @(posedge clk);
      #1;
      bus.UPDATE_SETTINGS = 1'b0;
   endtask

   task automatic set_seg(input int s, input logic [15:0] fd, input logic [14:0] cy);
      bus.FREQ_DIV[s] = fd;
      bus.CYCLE[s]    = cy;
   endtask

   initial begin
      total = 0;
      bad = 0;
      ph = 0;
      step_chk = 1'b0;
      time_mode = 0;
      rst_n = 1'b0;
      sys_time = 56'd123;
      bus.UPDATE_SETTINGS = 1'b0;
      for (int s = 0; s < NSEG; s++) begin
         exp_idx[s] = '0;
         have_last[s] = 1'b0;
         last_val[s] = '0;
      end
      set_seg(0, 16'd10, 15'd4);
      set_seg(1, 16'hFFFF, 15'h7FFF);
      cycles(3);
      rst_n = 1'b1;

      // basic division: 123/10 = 12, 12 mod 5 = 2
      cycles(3 * PERIOD);
      chk("basic_seg0", 64'(bus.SYNC_IDX[0]), 64'd2);

      // wide operands
      sys_time = 56'hFF_FFFF_FFFF_FFFF;
      pulse_update();
      cycles(2 * PERIOD + 4);

      // degenerate divisor and cycle
      time_mode = 2;
      set_seg(0, 16'd0, 15'd7);
      set_seg(1, 16'd300, 15'd0);
      pulse_update();
      cycles(4 * PERIOD + 4);
      chk("fd0_seg0", 64'(bus.SYNC_IDX[0]), 64'd0);
      chk("cy0_seg1", 64'(bus.SYNC_IDX[1]), 64'd0);

      // random settings
      for (int r = 0; r < 4; r++) begin
         for (int s = 0; s < NSEG; s++)
            set_seg(s, 16'($urandom_range(65535, 1)), 15'($urandom()));
         if (r == 1) set_seg(0, 16'($urandom_range(20, 1)), 15'h7FFF);
         pulse_update();
         cycles(2 * PERIOD + 4);
      end

      // update at cycle 60 of segment 1's computation
      time_mode = 1;
      set_seg(0, 16'd512, 15'd9);
      set_seg(1, 16'd512, 15'd9);
      pulse_update();
      cycles(PERIOD + 59);
      set_seg(0, 16'd300, 15'd9);
      set_seg(1, 16'd700, 15'd5);
      pulse_update();
      cycles(2 * PERIOD + 4);

      // asynchronous reset in the middle of DIV
      pulse_update();
      cycles(30);
      #2;
      rst_n = 1'b0;
      for (int s = 0; s < NSEG; s++) exp_idx[s] = '0;
      #1;
      chk("rst_idx_valid", 64'(bus.IDX_VALID), 64'd0);
      for (int s = 0; s < NSEG; s++) chk("rst_sync_idx", 64'(bus.SYNC_IDX[s]), 64'd0);
      cycles(3);
      rst_n = 1'b1;
      cycles(2 * PERIOD + 4);

      // free-running time: indices step by at most one and wrap
      set_seg(0, 16'd240, 15'd9);
      set_seg(1, 16'd240, 15'd9);
      step_chk = 1'b1;
      pulse_update();
      cycles(20 * 240 * 10);
      step_chk = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
